// File: rtl/store_aligner_pkg.sv
// Shared load/store definitions: access size codes, aligner states
// and the size-to-byte-mask helper.
package store_aligner_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001;
            SZ_HALF: m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_lane_mapper.sv
// Truncates store data to its size and rotates it onto the byte lanes;
// wide[7:4] holds the strobes that spill into the next word.
module store_lane_mapper
    import store_aligner_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    output logic [31:0] rot,
    output logic [7:0]  wide
);

    logic [3:0]  mask;
    logic [31:0] trunc;

    always_comb begin
        mask  = size_mask(size);
        trunc = data & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        case (off)
            2'd0:    rot = trunc;
            2'd1:    rot = {trunc[23:0], trunc[31:24]};
            2'd2:    rot = {trunc[15:0], trunc[31:16]};
            default: rot = {trunc[7:0], trunc[31:8]};
        endcase
        wide = {4'b0000, mask} << off;
    end

endmodule

// File: rtl/store_aligner.sv
// Store aligner: turns a sized, byte-addressed store into one or two
// word-aligned bus beats with byte strobes.
module store_aligner
    import store_aligner_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              done,
    output logic              err
);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       rot_q;
    logic [7:0]        wide_q;
    logic              done_q;
    logic              done_d;
    logic              err_q;
    logic [31:0]       rot_c;
    logic [7:0]        wide_c;
    logic              fire;
    logic              legal;

    store_lane_mapper u_map (
        .data (req_data),
        .off  (req_addr[1:0]),
        .size (req_size),
        .rot  (rot_c),
        .wide (wide_c)
    );

    assign fire  = req_valid && req_ready;
    assign legal = (req_size != SZ_ILL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            rot_q   <= '0;
            wide_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= fire && !legal;
            if (fire && legal) begin
                base_q <= {req_addr[ADDR_W-1:2], 2'b00};
                rot_q  <= rot_c;
                wide_q <= wide_c;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fire && legal) state_d = BEAT0;
            end
            BEAT0: begin
                if (mem_ready) begin
                    if (wide_q[7:4] != 4'b0000) begin
                        state_d = BEAT1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (mem_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode only from state and captured registers, never mem_ready.
    assign req_ready = (state_q == IDLE);
    assign mem_valid = (state_q != IDLE);
    assign mem_addr  = (state_q == BEAT1) ? base_q + ADDR_W'(4) : base_q;
    assign mem_wdata = rot_q;
    assign mem_be    = (state_q == BEAT0) ? wide_q[3:0] :
                       (state_q == BEAT1) ? wide_q[7:4] : 4'b0000;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_aligner.sv
// Randomised self-checking bench for store_aligner with a byte-level
// reference model and directed literal checks.
module tb_store_aligner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        done;
    logic        err;

    store_aligner #(.ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } beat_t;

    beat_t q[$];
    int    n_chk = 0;
    int    n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Model: place each stored byte at its own address, then group by word.
    task automatic model_push(input logic [31:0] addr, input logic [31:0] data,
                              input logic [1:0] size);
        beat_t       b[2];
        int          n;
        logic [31:0] base;
        logic [31:0] a;
        int          k;
        n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        base = addr & 32'hFFFF_FFFC;
        b[0] = '{base, 4'b0, 32'b0};
        b[1] = '{base + 32'd4, 4'b0, 32'b0};
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            k = int'((a - base) >> 2);
            b[k].be[a[1:0]] = 1'b1;
            b[k].data[8*a[1:0] +: 8] = data[8*i +: 8];
        end
        q.push_back(b[0]);
        if (b[1].be != 4'b0) q.push_back(b[1]);
    endtask

    logic done_exp = 1'b0;
    logic err_exp = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_req_ready", 32'(req_ready), 32'd1);
            chk("rst_mem_valid", 32'(mem_valid), 32'd0);
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
            chk("rst_mem_be", 32'(mem_be), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            q.delete();
            done_exp = 1'b0;
            err_exp  = 1'b0;
        end else begin
            chk("done", 32'(done), 32'(done_exp));
            chk("err", 32'(err), 32'(err_exp));
            chk("req_ready", 32'(req_ready), 32'(q.size() == 0));
            chk("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
            done_exp = 1'b0;
            err_exp  = 1'b0;
            if (mem_valid && q.size() != 0) begin
                chk("mem_addr", mem_addr, q[0].addr);
                chk("mem_be", 32'(mem_be), 32'(q[0].be));
                chk("mem_wdata", mem_wdata & lanes(q[0].be), q[0].data);
                if (mem_ready) begin
                    void'(q.pop_front());
                    if (q.size() == 0) done_exp = 1'b1;
                end
            end
            if (req_valid && req_ready) begin
                if (req_size == 2'd3) err_exp = 1'b1;
                else model_push(req_addr, req_data, req_size);
            end
        end
    end

    int stall_cycles = 0;
    bit stall_go = 1'b0;
    bit stall_seen = 1'b0;
    int stall_left = 0;
    bit rand_ready = 1'b0;

    always @(posedge clk) begin
        #1;
        if (stall_go != stall_seen) begin
            stall_left = stall_cycles;
            stall_seen = stall_go;
        end
        if (stall_left > 0 && mem_valid) begin
            mem_ready = 1'b0;
            stall_left--;
        end else begin
            mem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size, input bit wait_done,
                          output int lat);
        int guard;
        guard = 0;
        while (!req_ready && guard < 50) begin
            step();
            guard++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_data  = data;
        req_size  = size;
        step();
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        lat = 0;
        if (wait_done) begin
            while (!(done || err) && lat < 60) begin
                step();
                lat++;
            end
            chk("complete_timeout", 32'(done || err), 32'd1);
        end
    endtask

    task automatic beat(input string name, input logic [31:0] addr,
                        input logic [3:0] be);
        chk({name, "_valid"}, 32'(mem_valid), 32'd1);
        chk({name, "_addr"}, mem_addr, addr);
        chk({name, "_be"}, 32'(mem_be), 32'(be));
    endtask

    initial begin
        int          lat;
        logic [31:0] s_addr;
        logic [31:0] s_data;
        logic [3:0]  s_be;
        logic [1:0]  sz;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        do_req(32'h1002, 32'hDEAD_BEAB, 2'd0, 1'b0, lat);
        beat("byte", 32'h1000, 4'b0100);
        s_data = mem_wdata;
        chk("byte_lane2", 32'(s_data[23:16]), 32'hAB);
        step();
        chk("byte_done", 32'(done), 32'd1);
        chk("byte_ready", 32'(req_ready), 32'd1);

        do_req(32'h2003, 32'h0000_1234, 2'd1, 1'b0, lat);
        beat("half_b0", 32'h2000, 4'b1000);
        chk("half_b0_wdata", mem_wdata, 32'h3400_0012);
        step();
        beat("half_b1", 32'h2004, 4'b0001);
        chk("half_b1_wdata", mem_wdata, 32'h3400_0012);
        step();
        chk("half_done", 32'(done), 32'd1);

        do_req(32'h3001, 32'hAABB_CCDD, 2'd2, 1'b0, lat);
        beat("word_b0", 32'h3000, 4'b1110);
        chk("word_b0_wdata", mem_wdata, 32'hBBCC_DDAA);
        step();
        beat("word_b1", 32'h3004, 4'b0001);
        step();
        chk("word_done", 32'(done), 32'd1);

        do_req(32'h3000, 32'h1122_3344, 2'd2, 1'b0, lat);
        beat("word_al", 32'h3000, 4'b1111);
        chk("word_al_wdata", mem_wdata, 32'h1122_3344);
        step();
        chk("word_al_done", 32'(done), 32'd1);

        stall_cycles = 3;
        stall_go = ~stall_go;
        step();
        do_req(32'h4001, 32'h0000_0055, 2'd0, 1'b0, lat);
        s_addr = mem_addr;
        s_data = mem_wdata;
        s_be   = mem_be;
        beat("stall", 32'h4000, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr", mem_addr, s_addr);
            chk("stall_wdata", mem_wdata, s_data);
            chk("stall_be", 32'(mem_be), 32'(s_be));
            chk("stall_valid", 32'(mem_valid), 32'd1);
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_nodone", 32'(done), 32'd0);
        end
        step();
        chk("stall_done", 32'(done), 32'd1);

        do_req(32'hFFFF_FFFE, 32'hCAFE_F00D, 2'd2, 1'b0, lat);
        beat("wrap_b0", 32'hFFFF_FFFC, 4'b1100);
        step();
        beat("wrap_b1", 32'h0000_0000, 4'b0011);
        step();
        chk("wrap_done", 32'(done), 32'd1);

        do_req(32'h5000, 32'h1234_5678, 2'd3, 1'b0, lat);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_valid", 32'(mem_valid), 32'd0);
        chk("ill_ready", 32'(req_ready), 32'd1);
        step();
        chk("ill_err_once", 32'(err), 32'd0);
        chk("ill_valid2", 32'(mem_valid), 32'd0);

        do_req(32'h3001, 32'hAABB_CCDD, 2'd2, 1'b0, lat);
        step();
        beat("rst_b1", 32'h3004, 4'b0001);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(mem_valid), 32'd0);
        chk("mid_rst_be", 32'(mem_be), 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        step();
        reset = 1'b0;
        step();
        chk("post_rst_nodone", 32'(done), 32'd0);
        chk("post_rst_novalid", 32'(mem_valid), 32'd0);
        do_req(32'h6001, 32'h0000_BEEF, 2'd1, 1'b1, lat);
        chk("post_rst_lat", 32'(lat), 32'd1);

        do_req(32'h7002, 32'h0000_0011, 2'd0, 1'b1, lat);
        chk("b2b_lat1", 32'(lat), 32'd1);
        do_req(32'h7003, 32'h0000_0022, 2'd0, 1'b1, lat);
        chk("b2b_lat2", 32'(lat), 32'd1);
        do_req(32'h7003, 32'h0000_3344, 2'd1, 1'b1, lat);
        chk("split_lat", 32'(lat), 32'd2);

        rand_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            s_addr = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC | 32'($urandom_range(0, 3))
                                                 : $urandom;
            do_req(s_addr, $urandom, sz, 1'b1, lat);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
        end
        rand_ready = 1'b0;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
